// File: rtl/sv_mont_pkg.sv
// sv_mont_pkg: shared FSM type and parameter helpers for the sequential Montgomery multiplier.
package sv_mont_pkg;

    typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

    function automatic int rounds_per_op(input int n, input int r);
        return n / r;
    endfunction

    function automatic bit width_ok(input int n, input int r);
        return r >= 1 && r <= n && n % r == 0;
    endfunction

endpackage

// File: rtl/sv_mont_round.sv
// sv_mont_round: one combinational radix-2 Montgomery round, z_next = (z + a_bit*b [+ q]) / 2.
// Ports: q modulus, b multiplicand, a_bit current multiplier bit, z accumulator in, z_next accumulator out.
module sv_mont_round #(
    parameter int W = 512
) (
    input  logic [W-1:0] q,
    input  logic [W-1:0] b,
    input  logic         a_bit,
    input  logic [W+1:0] z,
    output logic [W+1:0] z_next
);

    logic [W+1:0] t;
    logic [W+1:0] u;

    assign t      = z + (a_bit ? {2'b00, b} : '0);
    // Adding the odd modulus makes t even so the halving is exact.
    assign u      = t[0] ? t + {2'b00, q} : t;
    assign z_next = u >> 1;

endmodule

// File: rtl/sv_mont_mul_seq.sv
// sv_mont_mul_seq: sequential Montgomery multiplier, result = A*B*2^-N mod Q, fully reduced.
// Ports: clk_i/rst_i clock and sync active-high reset; start_i/ready_o accept handshake;
//        abort_i cancels a running op; q_i/a_i/b_i operands sampled on accept;
//        done_o one-cycle pulse when result_o updates; result_o holds until next done_o.
module sv_mont_mul_seq
    import sv_mont_pkg::*;
#(
    parameter int DATA_WIDTH     = 512,
    parameter int ROUND_PER_TACT = 1
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  start_i,
    input  logic                  abort_i,
    input  logic [DATA_WIDTH-1:0] q_i,
    input  logic [DATA_WIDTH-1:0] a_i,
    input  logic [DATA_WIDTH-1:0] b_i,
    output logic                  ready_o,
    output logic                  done_o,
    output logic [DATA_WIDTH-1:0] result_o
);

    localparam int N   = DATA_WIDTH;
    localparam int R   = ROUND_PER_TACT;
    localparam int OPS = rounds_per_op(N, R);
    localparam int CW  = OPS > 1 ? $clog2(OPS) : 1;

    if (!width_ok(N, R)) begin : g_bad_width
        $error("DATA_WIDTH must be a multiple of ROUND_PER_TACT");
    end

    state_t       state;
    state_t       state_next;
    logic [N-1:0] q;
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic [N+1:0] z;
    logic [CW-1:0] cnt;
    logic [N+1:0] chain [0:R];
    logic [N-1:0] fixed;

    // R rounds chained per clock; round i consumes bit i of the shifting A register.
    assign chain[0] = z;
    for (genvar i = 0; i < R; i++) begin : g_round
        sv_mont_round #(.W(N)) u_round (
            .q      (q),
            .b      (b),
            .a_bit  (a[i]),
            .z      (chain[i]),
            .z_next (chain[i+1])
        );
    end

    // Z < 2Q, so one conditional subtraction yields a result in [0, Q).
    assign fixed   = (z >= {2'b00, q}) ? N'(z - {2'b00, q}) : z[N-1:0];
    assign ready_o = (state == IDLE);

    always_ff @(posedge clk_i) begin
        state <= rst_i ? IDLE : state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    state_next = start_i ? RUN : IDLE;
            RUN:     state_next = abort_i ? IDLE : (cnt == '0 ? FIX : RUN);
            FIX:     state_next = abort_i ? IDLE : IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            q        <= '0;
            a        <= '0;
            b        <= '0;
            z        <= '0;
            cnt      <= '0;
            done_o   <= 1'b0;
            result_o <= '0;
        end else begin
            done_o <= 1'b0;
            if (state == IDLE && start_i) begin
                q   <= q_i;
                a   <= a_i;
                b   <= b_i;
                z   <= '0;
                cnt <= CW'(OPS - 1);
            end else if (state == RUN && !abort_i) begin
                z <= chain[R];
                a <= a >> R;
                if (cnt != '0) cnt <= cnt - 1'b1;
            end else if (state == FIX && !abort_i) begin
                result_o <= fixed;
                done_o   <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_sv_mont_mul_seq.sv
// tb_sv_mont_mul_seq: directed self-checking bench for sv_mont_mul_seq at N=8 (R=1,4,8) and N=512 (R=1,16).
module tb_sv_mont_mul_seq;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic abort = 1'b0;
    always #5 clk = ~clk;

    logic [2:0]   start8 = '0;
    logic [2:0]   ready8;
    logic [2:0]   done8;
    logic [7:0]   q8 = '0, a8 = '0, b8 = '0;
    logic [7:0]   res8 [3];
    logic [1:0]   startl = '0;
    logic [1:0]   readyl;
    logic [1:0]   donel;
    logic [511:0] ql = '0, al = '0, bl = '0;
    logic [511:0] resl [2];

    int checks = 0;
    int failures = 0;

    sv_mont_mul_seq #(.DATA_WIDTH(8), .ROUND_PER_TACT(1)) d8r1 (
        .clk_i(clk), .rst_i(rst), .start_i(start8[0]), .abort_i(abort), .q_i(q8), .a_i(a8), .b_i(b8),
        .ready_o(ready8[0]), .done_o(done8[0]), .result_o(res8[0]));
    sv_mont_mul_seq #(.DATA_WIDTH(8), .ROUND_PER_TACT(4)) d8r4 (
        .clk_i(clk), .rst_i(rst), .start_i(start8[1]), .abort_i(abort), .q_i(q8), .a_i(a8), .b_i(b8),
        .ready_o(ready8[1]), .done_o(done8[1]), .result_o(res8[1]));
    sv_mont_mul_seq #(.DATA_WIDTH(8), .ROUND_PER_TACT(8)) d8r8 (
        .clk_i(clk), .rst_i(rst), .start_i(start8[2]), .abort_i(abort), .q_i(q8), .a_i(a8), .b_i(b8),
        .ready_o(ready8[2]), .done_o(done8[2]), .result_o(res8[2]));
    sv_mont_mul_seq #(.DATA_WIDTH(512), .ROUND_PER_TACT(1)) d512r1 (
        .clk_i(clk), .rst_i(rst), .start_i(startl[0]), .abort_i(abort), .q_i(ql), .a_i(al), .b_i(bl),
        .ready_o(readyl[0]), .done_o(donel[0]), .result_o(resl[0]));
    sv_mont_mul_seq #(.DATA_WIDTH(512), .ROUND_PER_TACT(16)) d512r16 (
        .clk_i(clk), .rst_i(rst), .start_i(startl[1]), .abort_i(abort), .q_i(ql), .a_i(al), .b_i(bl),
        .ready_o(readyl[1]), .done_o(donel[1]), .result_o(resl[1]));

    // Called at a negedge; returns at the negedge after the accept edge.
    task automatic go8(input int s, input logic [7:0] q, input logic [7:0] a, input logic [7:0] b);
        q8 = q; a8 = a; b8 = b; start8[s] = 1'b1;
        @(negedge clk);
        start8[s] = 1'b0;
    endtask

    task automatic wait8(input int s, output int lat);
        lat = 0;
        for (int k = 1; k <= 600; k++) begin
            @(negedge clk);
            if (done8[s]) begin lat = k; break; end
        end
    endtask

    task automatic gol(input int s, input logic [511:0] q, input logic [511:0] a, input logic [511:0] b);
        ql = q; al = a; bl = b; startl[s] = 1'b1;
        @(negedge clk);
        startl[s] = 1'b0;
    endtask

    task automatic waitl(input int s, output int lat);
        lat = 0;
        for (int k = 1; k <= 600; k++) begin
            @(negedge clk);
            if (donel[s]) begin lat = k; break; end
        end
    endtask

    // A*B mod Q by plain double-and-add.
    function automatic logic [513:0] mulmod(input logic [511:0] a, input logic [511:0] b, input logic [511:0] q);
        logic [513:0] r = '0;
        for (int i = 511; i >= 0; i--) begin
            r = r << 1;
            if (r >= {2'b00, q}) r = r - {2'b00, q};
            if (a[i]) begin
                r = r + {2'b00, b};
                if (r >= {2'b00, q}) r = r - {2'b00, q};
            end
        end
        return r;
    endfunction

    // x*2^512 mod Q by repeated modular doubling.
    function automatic logic [513:0] scale(input logic [511:0] x, input logic [511:0] q);
        logic [513:0] r = {2'b00, x};
        for (int i = 0; i < 512; i++) begin
            r = r << 1;
            if (r >= {2'b00, q}) r = r - {2'b00, q};
        end
        return r;
    endfunction

    function automatic logic [511:0] rnd512();
        logic [511:0] v;
        for (int i = 0; i < 16; i++) v[i*32 +: 32] = $urandom;
        return v;
    endfunction

    task automatic test_reset;
        repeat (3) @(negedge clk);
        checks++; if (ready8 !== 3'b111) begin failures++; $display("FAIL reset_ready8: got %b expected 111", ready8); end
        checks++; if (done8 !== 3'b000) begin failures++; $display("FAIL reset_done8: got %b expected 000", done8); end
        for (int s = 0; s < 3; s++) begin
            checks++; if (res8[s] !== 8'd0) begin failures++; $display("FAIL reset_result8[%0d]: got %0d expected 0", s, res8[s]); end
        end
        checks++; if (readyl !== 2'b11) begin failures++; $display("FAIL reset_readyl: got %b expected 11", readyl); end
        checks++; if (donel !== 2'b00) begin failures++; $display("FAIL reset_donel: got %b expected 00", donel); end
        checks++; if (resl[0] !== '0) begin failures++; $display("FAIL reset_resultl: got %h expected 0", resl[0]); end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_basic;
        logic [7:0] vq [5] = '{8'd13, 8'd13, 8'd13, 8'd255, 8'd13};
        logic [7:0] va [5] = '{8'd5, 8'd1, 8'd12, 8'd254, 8'd12};
        logic [7:0] vb [5] = '{8'd7, 8'd1, 8'd1, 8'd254, 8'd12};
        logic [7:0] ve [5] = '{8'd1, 8'd3, 8'd10, 8'd1, 8'd3};
        int lat;
        for (int v = 0; v < 5; v++) begin
            go8(0, vq[v], va[v], vb[v]);
            checks++; if (ready8[0] !== 1'b0) begin failures++; $display("FAIL basic_busy[%0d]: got %b expected 0", v, ready8[0]); end
            wait8(0, lat);
            checks++; if (lat != 9) begin failures++; $display("FAIL basic_latency[%0d]: got %0d expected 9", v, lat); end
            checks++; if (res8[0] !== ve[v]) begin failures++; $display("FAIL basic_result[%0d]: got %0d expected %0d", v, res8[0], ve[v]); end
        end
    endtask

    task automatic test_rounds_per_tact;
        int lat;
        go8(1, 8'd13, 8'd12, 8'd12);
        wait8(1, lat);
        checks++; if (lat != 3) begin failures++; $display("FAIL r4_latency: got %0d expected 3", lat); end
        checks++; if (res8[1] !== 8'd3) begin failures++; $display("FAIL r4_result: got %0d expected 3", res8[1]); end
        go8(1, 8'd13, 8'd5, 8'd7);
        wait8(1, lat);
        checks++; if (res8[1] !== 8'd1) begin failures++; $display("FAIL r4_result2: got %0d expected 1", res8[1]); end
        go8(2, 8'd13, 8'd12, 8'd12);
        wait8(2, lat);
        checks++; if (lat != 2) begin failures++; $display("FAIL r8_latency: got %0d expected 2", lat); end
        checks++; if (res8[2] !== 8'd3) begin failures++; $display("FAIL r8_result: got %0d expected 3", res8[2]); end
    endtask

    task automatic test_back_to_back;
        int lat;
        go8(0, 8'd13, 8'd0, 8'd9);
        wait8(0, lat);
        checks++; if (lat != 9) begin failures++; $display("FAIL b2b_latency1: got %0d expected 9", lat); end
        checks++; if (res8[0] !== 8'd0) begin failures++; $display("FAIL b2b_result1: got %0d expected 0", res8[0]); end
        checks++; if (ready8[0] !== 1'b1) begin failures++; $display("FAIL b2b_ready_in_done: got %b expected 1", ready8[0]); end
        go8(0, 8'd13, 8'd5, 8'd7);
        checks++; if (done8[0] !== 1'b0) begin failures++; $display("FAIL b2b_done_width: got %b expected 0", done8[0]); end
        checks++; if (ready8[0] !== 1'b0) begin failures++; $display("FAIL b2b_no_bubble: got %b expected 0", ready8[0]); end
        wait8(0, lat);
        checks++; if (lat != 9) begin failures++; $display("FAIL b2b_latency2: got %0d expected 9", lat); end
        checks++; if (res8[0] !== 8'd1) begin failures++; $display("FAIL b2b_result2: got %0d expected 1", res8[0]); end
    endtask

    task automatic test_abort;
        int lat;
        bit seen = 1'b0;
        go8(0, 8'd13, 8'd12, 8'd12);
        repeat (4) @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        checks++; if (ready8[0] !== 1'b1) begin failures++; $display("FAIL abort_ready: got %b expected 1", ready8[0]); end
        checks++; if (done8[0] !== 1'b0) begin failures++; $display("FAIL abort_done: got %b expected 0", done8[0]); end
        checks++; if (res8[0] !== 8'd1) begin failures++; $display("FAIL abort_result_held: got %0d expected 1", res8[0]); end
        repeat (12) begin
            @(negedge clk);
            if (done8[0]) seen = 1'b1;
        end
        checks++; if (seen) begin failures++; $display("FAIL abort_no_done: got 1 expected 0"); end
        abort = 1'b1;
        go8(0, 8'd13, 8'd12, 8'd12);
        abort = 1'b0;
        checks++; if (ready8[0] !== 1'b0) begin failures++; $display("FAIL abort_start_wins: got %b expected 0", ready8[0]); end
        wait8(0, lat);
        checks++; if (lat != 9) begin failures++; $display("FAIL abort_fresh_latency: got %0d expected 9", lat); end
        checks++; if (res8[0] !== 8'd3) begin failures++; $display("FAIL abort_fresh_result: got %0d expected 3", res8[0]); end
    endtask

    task automatic test_start_ignored;
        int lat;
        go8(0, 8'd13, 8'd5, 8'd7);
        repeat (3) @(negedge clk);
        q8 = 8'd13; a8 = 8'd12; b8 = 8'd1; start8[0] = 1'b1;
        @(negedge clk);
        start8[0] = 1'b0;
        wait8(0, lat);
        checks++; if (lat != 5) begin failures++; $display("FAIL ignore_latency: got %0d expected 5", lat); end
        checks++; if (res8[0] !== 8'd1) begin failures++; $display("FAIL ignore_result: got %0d expected 1", res8[0]); end
    endtask

    task automatic test_reset_mid;
        bit seen = 1'b0;
        go8(0, 8'd13, 8'd12, 8'd1);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks++; if (ready8[0] !== 1'b1) begin failures++; $display("FAIL rstmid_ready: got %b expected 1", ready8[0]); end
        checks++; if (done8[0] !== 1'b0) begin failures++; $display("FAIL rstmid_done: got %b expected 0", done8[0]); end
        checks++; if (res8[0] !== 8'd0) begin failures++; $display("FAIL rstmid_result: got %0d expected 0", res8[0]); end
        repeat (12) begin
            @(negedge clk);
            if (done8[0]) seen = 1'b1;
        end
        checks++; if (seen) begin failures++; $display("FAIL rstmid_no_done: got 1 expected 0"); end
    endtask

    task automatic test_large;
        logic [511:0] q, a, b;
        logic [513:0] want, got;
        int lat;
        for (int v = 0; v < 2; v++) begin
            q = rnd512(); q[511] = 1'b1; q[0] = 1'b1;
            a = rnd512(); a[511] = 1'b0;
            b = rnd512(); b[511] = 1'b0;
            want = mulmod(a, b, q);
            for (int s = 0; s < 2; s++) begin
                gol(s, q, a, b);
                waitl(s, lat);
                checks++; if (lat != (s == 0 ? 513 : 33)) begin failures++; $display("FAIL large_latency[%0d][%0d]: got %0d expected %0d", v, s, lat, s == 0 ? 513 : 33); end
                checks++; if (resl[s] >= q) begin failures++; $display("FAIL large_reduced[%0d][%0d]: got %h", v, s, resl[s]); end
                got = scale(resl[s], q);
                checks++; if (got !== want) begin failures++; $display("FAIL large_result[%0d][%0d]: got %h expected %h", v, s, got, want); end
            end
        end
    endtask

    initial begin
        @(negedge clk);
        test_reset;
        test_basic;
        test_rounds_per_tact;
        test_back_to_back;
        test_abort;
        test_start_ignored;
        test_reset_mid;
        test_large;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
